// File: rtl/dsp_issue_ctrl.sv
// Issue controller for a small DSP datapath: register file, busy scoreboard,
// in-order single-issue of ADD/MPY to an external execution unit, LD/MOV
// retired locally, and result writeback.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | accepting instructions (stalls on scoreboard hazard)
//   S_ISSUE | ADD/MPY operands presented, waiting for iss_ready
module dsp_issue_ctrl #(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int IMMW = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_op,
    input  logic [4:0]      in_rs,
    input  logic [4:0]      in_rt,
    input  logic [4:0]      in_rd,
    input  logic [IMMW-1:0] in_imm,
    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [DW-1:0]   iss_a,
    output logic [DW-1:0]   iss_b,
    output logic [2:0]      iss_func,
    output logic [4:0]      iss_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [DW-1:0]   wb_data,
    input  logic [4:0]      dbg_addr,
    output logic [DW-1:0]   dbg_data,
    output logic [NREG-1:0] busy_vec,
    output logic            err_illegal
);

    localparam logic [5:0] OP_LD   = 6'd1;
    localparam logic [5:0] OP_MPY  = 6'd2;
    localparam logic [5:0] OP_ADD  = 6'd3;
    localparam logic [5:0] OP_MOV  = 6'd4;
    localparam logic [2:0] FN_ADD  = 3'd1;
    localparam logic [2:0] FN_MPY  = 3'd2;
    localparam logic [5:0] NREG_W  = 6'(NREG);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   regs [32];
    logic [31:0]     busy_all;
    logic            is_ld, is_mov, is_arith;
    logic            use_rs, use_rt, use_rd;
    logic            illegal, hazard;
    logic            accept, ins_do, ins_we, wb_ok;
    logic [DW-1:0]   ins_wdata;
    logic [31:0]     wb_clr, iss_set;

    // Entries at or above NREG are tied to zero so any 5-bit index reads safely.
    assign busy_all = 32'(busy_vec);

    // Instruction decode, legality and scoreboard hazard; illegal ones never stall.
    always_comb begin
        is_ld    = (in_op == OP_LD);
        is_mov   = (in_op == OP_MOV);
        is_arith = (in_op == OP_ADD) || (in_op == OP_MPY);
        use_rs   = is_mov || is_arith;
        use_rt   = is_arith;
        use_rd   = is_ld || is_mov || is_arith;
        illegal  = (in_op > OP_MOV)
                || (use_rs && ({1'b0, in_rs} >= NREG_W))
                || (use_rt && ({1'b0, in_rt} >= NREG_W))
                || (use_rd && ({1'b0, in_rd} >= NREG_W));
        hazard   = !illegal && ((use_rs && busy_all[in_rs])
                             || (use_rt && busy_all[in_rt])
                             || (use_rd && busy_all[in_rd]));
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        iss_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !hazard;
                if (in_valid && !hazard && !illegal && is_arith)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                iss_valid = 1'b1;
                if (iss_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write strobes shared by the register file and scoreboard.
    always_comb begin
        accept    = in_valid && in_ready;
        ins_do    = accept && !illegal;
        ins_we    = ins_do && (is_ld || is_mov);
        ins_wdata = is_ld ? DW'(in_imm) : regs[in_rs];
        wb_ok     = wb_valid && ({1'b0, wb_rd} < NREG_W);
        wb_clr    = wb_ok ? (32'd1 << wb_rd) : 32'd0;
        iss_set   = (ins_do && is_arith) ? (32'd1 << in_rd) : 32'd0;
    end

    for (genvar g = 0; g < 32; g++) begin : g_reg
        if (g < NREG) begin : g_used
            logic [DW-1:0] q;
            // Register entry: local LD/MOV result takes precedence over writeback.
            always_ff @(posedge clk) begin
                if (!nrst)
                    q <= '0;
                else if (ins_we && (in_rd == 5'(g)))
                    q <= ins_wdata;
                else if (wb_ok && (wb_rd == 5'(g)))
                    q <= wb_data;
            end
            assign regs[g] = q;
        end else begin : g_unused
            assign regs[g] = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nrst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Scoreboard, issue operand latch and illegal-instruction pulse.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            busy_vec    <= '0;
            iss_a       <= '0;
            iss_b       <= '0;
            iss_func    <= '0;
            iss_rd      <= '0;
            err_illegal <= 1'b0;
        end else begin
            busy_vec    <= (busy_vec & ~wb_clr[NREG-1:0]) | iss_set[NREG-1:0];
            err_illegal <= accept && illegal;
            if (ins_do && is_arith) begin
                iss_a    <= regs[in_rs];
                iss_b    <= regs[in_rt];
                iss_func <= (in_op == OP_ADD) ? FN_ADD : FN_MPY;
                iss_rd   <= in_rd;
            end
        end
    end

    assign dbg_data = ({1'b0, dbg_addr} < NREG_W) ? regs[dbg_addr] : '0;

endmodule

// File: doc/dsp_issue_ctrl.md
DSP_ISSUE_CTRL -- requirements
Module: dsp_issue_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DW, 32, data/register width; NREG, 16, register count (2..32); IMMW, 8, immediate width (IMMW <= DW).
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 nrst  in  1  reset; synchronous, active-low.
REQ-004 in_valid  in  1  instruction offered.
REQ-005 in_ready  out  1  instruction accepted this cycle when in_valid & in_ready.
REQ-006 in_op  in  6  opcode: 1=LD, 2=MPY, 3=ADD, 4=MOV, 0=NOP; all others illegal.
REQ-007 in_rs, in_rt, in_rd  in  5 each  register indices.
REQ-008 in_imm  in  IMMW  immediate for LD.
REQ-009 iss_valid  out  1  operands valid to the execution unit.
REQ-010 iss_ready  in  1  execution unit accepts when iss_valid & iss_ready.
REQ-011 iss_a, iss_b  out  DW each  operands; iss_func  out  3  1=ADD, 2=MPY; iss_rd  out  5  destination tag.
REQ-012 wb_valid  in  1; wb_rd  in  5; wb_data  in  DW  result writeback.
REQ-013 dbg_addr  in  5; dbg_data  out  DW  combinational register read, 0 when dbg_addr >= NREG.
REQ-014 busy_vec  out  NREG  scoreboard, bit i = register i awaiting writeback.
REQ-015 err_illegal  out  1  one-cycle pulse on an illegal instruction.

Function
REQ-016 Register file SHALL hold NREG x DW entries; all indices 0..NREG-1 SHALL be writable.
REQ-017 FSM states: IDLE (in_ready=1), ISSUE (iss_valid=1, in_ready=0).
REQ-018 IDLE: instruction SHALL be accepted only if no hazard; hazard = busy on any used source (ADD/MPY: rs,rt; MOV: rs) or on rd (LD, MOV, ADD, MPY); when a hazard is present, in_ready SHALL be 0.
REQ-019 LD accepted: reg[rd] <= zero-extended in_imm on the next edge; FSM stays IDLE.
REQ-020 MOV accepted: reg[rd] <= reg[rs] on the next edge; FSM stays IDLE.
REQ-021 NOP accepted: no state change.
REQ-022 ADD/MPY accepted: iss_a <= reg[rs], iss_b <= reg[rt], iss_func, iss_rd <= rd registered; busy[rd] set; FSM -> ISSUE; iss_valid asserted the following cycle.
REQ-023 ISSUE: iss_a/b/func/rd SHALL be held stable until iss_ready=1; then FSM -> IDLE the next cycle.
REQ-024 Illegal opcode, or any used index >= NREG: instruction SHALL be consumed, no register or scoreboard change, err_illegal pulsed for one cycle the cycle after acceptance.
REQ-025 wb_valid with wb_rd < NREG: reg[wb_rd] <= wb_data and busy[wb_rd] cleared; wb_rd >= NREG ignored.
REQ-026 Same-cycle writeback and hazard check: the check SHALL use the pre-edge busy_vec (no bypass); acceptance occurs the next cycle.
REQ-027 Same-cycle writeback and ADD/MPY operand read of a different register: both SHALL proceed.
REQ-028 Same-cycle writeback clearing busy[x] and new issue setting busy[y]: both SHALL take effect; x=y is impossible by REQ-018.
REQ-029 Arithmetic is out of scope; iss_* SHALL carry full DW operands with no truncation.

Reset
REQ-030 nrst=0 at an edge: all registers, busy_vec, iss_a, iss_b, iss_func, iss_rd SHALL be 0; err_illegal=0; FSM=IDLE; iss_valid=0.
REQ-031 Reset in ISSUE SHALL abandon the pending issue; a wb_valid in the reset cycle SHALL be ignored.

Verification
REQ-032 LD r1,#0x5A then LD r2,#0x03, then dbg_addr=1/2 -> dbg_data 0x5A/0x03.
REQ-033 ADD r3,r1,r2 with iss_ready held low 3 cycles -> iss_valid=1, iss_a=0x5A, iss_b=0x03, iss_func=1, iss_rd=3 stable for all 3 cycles; busy_vec[3]=1.
REQ-034 MPY r4,r3,r1 while busy[3]=1 -> in_ready=0 until wb_valid, wb_rd=3, wb_data=0x5D; acceptance next cycle; issued iss_a=0x5D.
REQ-035 in_op=7, or LD with rd=NREG -> err_illegal single pulse; register file and busy_vec unchanged.
REQ-036 Reset asserted in ISSUE -> next cycle iss_valid=0, busy_vec=0, dbg_data=0 for every address.
REQ-037 MOV r5,r1 immediately followed by LD r1,#0x11 -> r5=0x5A, r1=0x11.
